// File: rtl/tx_cp_insert_pkg.sv
// rtl/tx_cp_insert_pkg.sv - shared OFDM Tx encodings and cyclic-prefix length helper
package ofdm_tx_pkg;

  typedef enum logic [1:0] {
    CP_QUARTER = 2'd0,
    CP_EIGHTH  = 2'd1,
    CP_16TH    = 2'd2,
    CP_32ND    = 2'd3
  } cp_sel_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_CP   = 2'd1,
    RD_BODY = 2'd2
  } rd_state_e;

  // CP length in samples: NFFT/4 down to NFFT/32.
  function automatic int unsigned cp_len(input int unsigned nfft, input cp_sel_e sel);
    return nfft >> (2 + int'(sel));
  endfunction

endpackage

// File: rtl/tx_cp_insert_if.sv
// rtl/tx_cp_insert_if.sv - sample bus (write/strobe/cycle/ack handshake) between Tx chain stages
interface tx_cp_insert_if #(parameter int DW = 32);
  logic [DW-1:0] dat;
  logic          we;
  logic          stb;
  logic          cyc;
  logic          ack;

  modport master (output dat, output we, output stb, output cyc, input ack);
  modport slave  (input dat, input we, input stb, input cyc, output ack);
endinterface

// File: rtl/tx_cp_insert_dpram.sv
// rtl/tx_cp_insert_dpram.sv - simple dual-port sample RAM, one write port and one registered read port
module cp_dpram #(
  parameter int DW    = 32,
  parameter int DEPTH = 128,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/tx_cp_insert.sv
// rtl/tx_cp_insert.sv - cyclic-prefix insertion over a ping-pong symbol buffer
// Writer fills one bank while the reader replays the tail of the other bank then its full body.
module tx_cp_insert
  import ofdm_tx_pkg::*;
#(
  parameter int NFFT = 64,
  parameter int DW   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cp_sel,
  tx_cp_insert_if.slave         s_in,
  tx_cp_insert_if.master        m_out
);

  localparam int AW = $clog2(NFFT);
  localparam logic [AW-1:0] LAST = AW'(NFFT - 1);

  rd_state_e     state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt, cpl, cpl_nxt, rd_idx, wr_idx;
  logic          rd_bank, rd_bank_nxt, other_bank, wr_bank;
  logic [1:0]    full, full_nxt;
  logic          in_xfer, wr_done, issue, issue_last, advance, release_bank;
  logic          valid, q_last, q_bank;
  logic [DW-1:0] q;

  assign s_in.ack     = ~rst & s_in.stb & s_in.cyc & s_in.we & ~full[wr_bank];
  assign in_xfer      = s_in.ack;
  assign wr_done      = in_xfer & (wr_idx == LAST);
  assign other_bank   = ~rd_bank;
  // The RAM read register doubles as the output register, so reads only advance when it drains.
  assign advance      = ~valid | m_out.ack;
  assign release_bank = valid & m_out.ack & q_last;

  always_comb begin
    full_nxt = full;
    if (release_bank) full_nxt[q_bank] = 1'b0;
    if (wr_done)      full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx  <= '0;
      wr_bank <= 1'b0;
      full    <= '0;
    end else begin
      if (in_xfer) wr_idx <= wr_done ? '0 : wr_idx + AW'(1);
      if (wr_done) wr_bank <= ~wr_bank;
      full <= full_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cpl_nxt     = cpl;
    rd_bank_nxt = rd_bank;
    issue       = 1'b0;
    issue_last  = 1'b0;
    rd_idx      = cnt;
    unique case (state)
      RD_IDLE: begin
        if (full[rd_bank]) begin
          state_nxt = RD_CP;
          cnt_nxt   = '0;
          cpl_nxt   = AW'(cp_len(NFFT, cp_sel_e'(cp_sel)));
        end
      end
      RD_CP: begin
        if (advance) begin
          issue  = 1'b1;
          rd_idx = cnt - cpl;
          if (cnt == cpl - AW'(1)) begin
            state_nxt = RD_BODY;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + AW'(1);
          end
        end
      end
      RD_BODY: begin
        if (advance) begin
          issue = 1'b1;
          if (cnt == LAST) begin
            issue_last  = 1'b1;
            rd_bank_nxt = other_bank;
            cnt_nxt     = '0;
            if (full[other_bank]) begin
              state_nxt = RD_CP;
              cpl_nxt   = AW'(cp_len(NFFT, cp_sel_e'(cp_sel)));
            end else begin
              state_nxt = RD_IDLE;
            end
          end else begin
            cnt_nxt = cnt + AW'(1);
          end
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RD_IDLE;
      cnt     <= '0;
      cpl     <= AW'(NFFT / 4);
      rd_bank <= 1'b0;
      valid   <= 1'b0;
      q_last  <= 1'b0;
      q_bank  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cpl     <= cpl_nxt;
      rd_bank <= rd_bank_nxt;
      if (issue) begin
        valid  <= 1'b1;
        q_last <= issue_last;
        q_bank <= rd_bank;
      end else if (m_out.ack) begin
        valid <= 1'b0;
      end
    end
  end

  cp_dpram #(.DW(DW), .DEPTH(2 * NFFT)) u_ram (
    .clk   (clk),
    .we    (in_xfer),
    .waddr ({wr_bank, wr_idx}),
    .wdata (s_in.dat),
    .re    (issue),
    .raddr ({rd_bank, rd_idx}),
    .rdata (q)
  );

  assign m_out.stb = valid;
  assign m_out.cyc = valid;
  assign m_out.we  = valid;
  assign m_out.dat = valid ? q : '0;

endmodule

// File: tb/tb_tx_cp_insert.sv
// tb/tb_tx_cp_insert.sv - self-checking bench for tx_cp_insert against a symbol-level CP model
module tb_tx_cp_insert;

  localparam int NFFT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cp_sel = 2'd0;

  tx_cp_insert_if #(.DW(32)) in_if();
  tx_cp_insert_if #(.DW(32)) out_if();

  tx_cp_insert #(.NFFT(NFFT), .DW(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .cp_sel (cp_sel),
    .s_in   (in_if.slave),
    .m_out  (out_if.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] in_q[$];
  logic [31:0] exp_q[$];
  int          exp_len_q[$];
  int          full_count, in_pos, out_pos;
  int          gaps, stalls, first_stb_i, last_in_i;

  // Symbol model: CP is the last NFFT/(4<<sel) samples, followed by the whole symbol.
  task automatic push_symbol(input int first, input bit rnd, input int sel);
    logic [31:0] s[NFFT];
    int cpl;
    cpl = NFFT / (4 << sel);
    for (int k = 0; k < NFFT; k++) begin
      s[k] = rnd ? $urandom : 32'(first + k);
      in_q.push_back(s[k]);
    end
    for (int k = NFFT - cpl; k < NFFT; k++) exp_q.push_back(s[k]);
    for (int k = 0; k < NFFT; k++) exp_q.push_back(s[k]);
    exp_len_q.push_back(NFFT + cpl);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_if.stb = 1'b0; in_if.cyc = 1'b0; in_if.we = 1'b0; in_if.dat = '0;
    out_if.ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_q.delete(); exp_q.delete(); exp_len_q.delete();
    full_count = 0; in_pos = 0; out_pos = 0;
  endtask

  // ack_mode: 0 always ready, 1 toggles every 3 cycles, 2 random; gap_pct: input idle percentage
  task automatic run(input int ack_mode, input int gap_pct, input int sel_iter,
                     input logic [1:0] sel_new, input int budget);
    int i;
    bit hold, started, exp_ack;
    logic [31:0] hold_dat;
    i = 0; hold = 0; started = 0; hold_dat = '0;
    gaps = 0; stalls = 0; first_stb_i = -1; last_in_i = -1;
    while ((in_q.size() > 0 || exp_q.size() > 0) && i < budget) begin
      @(posedge clk);
      #1;
      i++;
      if (sel_iter > 0 && i == sel_iter) cp_sel = sel_new;
      in_if.stb = (in_q.size() > 0) && ($urandom_range(99) >= gap_pct);
      in_if.cyc = in_if.stb;
      in_if.we  = in_if.stb;
      in_if.dat = (in_q.size() > 0) ? in_q[0] : '0;
      case (ack_mode)
        0: out_if.ack = 1'b1;
        1: out_if.ack = ((i / 3) % 2) == 0;
        default: out_if.ack = $urandom_range(3) != 0;
      endcase
      @(negedge clk);
      exp_ack = in_if.stb && (full_count < 2);
      n_vec++;
      if (in_if.ack !== exp_ack) begin
        n_err++;
        $display("FAIL ack_o iter %0d: got %b expected %b (full banks %0d)", i, in_if.ack, exp_ack, full_count);
      end
      if (in_if.stb && !in_if.ack) stalls++;
      if (hold) begin
        n_vec++;
        if (out_if.stb !== 1'b1 || out_if.dat !== hold_dat) begin
          n_err++;
          $display("FAIL hold iter %0d: got stb=%b dat=%0d expected stb=1 dat=%0d", i, out_if.stb, out_if.dat, hold_dat);
        end
      end
      hold = out_if.stb && !out_if.ack;
      hold_dat = out_if.dat;
      if (out_if.stb && first_stb_i < 0) first_stb_i = i;
      if (out_if.stb) started = 1;
      if (started && exp_q.size() > 0 && !out_if.stb) gaps++;
      // Model state advances with the transfers taken at the coming edge: release before fill.
      if (out_if.stb && out_if.ack) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_output iter %0d: got dat=%0d expected no output", i, out_if.dat);
        end else begin
          if (out_if.dat !== exp_q[0] || out_if.cyc !== 1'b1 || out_if.we !== 1'b1) begin
            n_err++;
            $display("FAIL dat_o iter %0d: got %0d cyc=%b we=%b expected %0d cyc=1 we=1", i, out_if.dat, out_if.cyc, out_if.we, exp_q[0]);
          end
          void'(exp_q.pop_front());
          out_pos++;
          if (out_pos == exp_len_q[0]) begin
            void'(exp_len_q.pop_front());
            out_pos = 0;
            full_count--;
          end
        end
      end
      if (in_if.stb && in_if.ack) begin
        void'(in_q.pop_front());
        last_in_i = i;
        in_pos++;
        if (in_pos == NFFT) begin
          in_pos = 0;
          full_count++;
        end
      end
    end
    n_vec++;
    if (in_q.size() > 0 || exp_q.size() > 0) begin
      n_err++;
      $display("FAIL timeout: got %0d inputs / %0d outputs pending expected 0 / 0", in_q.size(), exp_q.size());
      in_q.delete(); exp_q.delete(); exp_len_q.delete();
    end
    @(posedge clk);
    #1;
    in_if.stb = 1'b0; in_if.cyc = 1'b0; in_if.we = 1'b0;
    out_if.ack = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_if.stb !== 1'b0 || out_if.cyc !== 1'b0 || out_if.we !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_last: got stb=%b cyc=%b we=%b expected 0 0 0", out_if.stb, out_if.cyc, out_if.we);
    end
  endtask

  task automatic test_reset();
    in_if.stb = 1'b1; in_if.cyc = 1'b1; in_if.we = 1'b1; in_if.dat = 32'h1234;
    out_if.ack = 1'b1;
    #12;
    n_vec++;
    if (in_if.ack !== 1'b0) begin
      n_err++; $display("FAIL reset_ack_o: got %b expected 0", in_if.ack);
    end
    n_vec++;
    if ({out_if.stb, out_if.cyc, out_if.we} !== 3'b000 || out_if.dat !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got stb=%b cyc=%b we=%b dat=%0d expected all 0", out_if.stb, out_if.cyc, out_if.we, out_if.dat);
    end
    apply_reset();
  endtask

  task automatic test_single_symbol();
    apply_reset();
    cp_sel = 2'd0;
    push_symbol(1, 0, 0);
    run(0, 0, 0, 2'd0, 400);
    n_vec++;
    if (first_stb_i - last_in_i !== 3) begin
      n_err++;
      $display("FAIL latency: got first stb %0d cycles after last input sample expected 3", first_stb_i - last_in_i);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    cp_sel = 2'd1;
    for (int s = 0; s < 3; s++) push_symbol(1 + s * NFFT, 0, 1);
    run(0, 0, 0, 2'd0, 1000);
    n_vec++;
    if (gaps !== 0) begin
      n_err++; $display("FAIL back_to_back_gaps: got %0d idle cycles expected 0", gaps);
    end
    n_vec++;
    if (stalls == 0) begin
      n_err++; $display("FAIL back_to_back_stall: got %0d stalled input cycles expected >0", stalls);
    end
  endtask

  task automatic test_ack_toggle();
    int sel;
    apply_reset();
    sel = $urandom_range(3);
    cp_sel = 2'(sel);
    push_symbol(0, 1, sel);
    push_symbol(0, 1, sel);
    run(1, 0, 0, 2'd0, 2000);
  endtask

  task automatic test_cp_sel_change();
    apply_reset();
    cp_sel = 2'd3;
    push_symbol(1, 0, 3);
    push_symbol(65, 0, 0);
    run(0, 0, 70, 2'd0, 1000);
  endtask

  task automatic test_reset_mid_symbol();
    apply_reset();
    cp_sel = 2'd0;
    for (int k = 0; k < 30; k++) in_q.push_back($urandom);
    run(0, 0, 0, 2'd0, 200);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_if.stb = 1'b1; in_if.cyc = 1'b1; in_if.we = 1'b1;
    #1;
    n_vec++;
    if (in_if.ack !== 1'b0 || out_if.stb !== 1'b0 || out_if.cyc !== 1'b0 || out_if.dat !== 32'd0) begin
      n_err++;
      $display("FAIL mid_reset: got ack=%b stb=%b cyc=%b dat=%0d expected all 0", in_if.ack, out_if.stb, out_if.cyc, out_if.dat);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_if.stb = 1'b0; in_if.cyc = 1'b0; in_if.we = 1'b0;
    in_q.delete(); exp_q.delete(); exp_len_q.delete();
    full_count = 0; in_pos = 0; out_pos = 0;
    push_symbol(101, 0, 0);
    run(0, 0, 0, 2'd0, 400);
  endtask

  task automatic test_random();
    int sel;
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      sel = $urandom_range(3);
      cp_sel = 2'(sel);
      for (int s = 0; s < 3; s++) push_symbol(0, 1, sel);
      run(2, 30, 0, 2'd0, 3000);
    end
  endtask

  initial begin
    test_reset();
    test_single_symbol();
    test_back_to_back();
    test_ack_toggle();
    test_cp_sel_change();
    test_reset_mid_symbol();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
